// File: rtl/sersub_pkg.sv
// Shared types and helpers for the nibble-serial subtractor.
// Optional zero flag is enabled with SERSUB_ZERO_EN.
package sersub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for serial_sub_ctrl.
// The zero signal exists only with SERSUB_ZERO_EN.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERSUB_ZERO_EN
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif

endinterface

// File: rtl/sub4_slice.sv
// Combinational 4-bit borrow-chain subtractor slice.
// Build option SERSUB_ZERO_EN does not affect this file.
module sub4_slice
  import sersub_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               bi,
  output logic [SLICE_W-1:0] d4,
  output logic               bo
);

  // A negative 5-bit result leaves bit 4 set, which is the borrow.
  assign {bo, d4} = {1'b0, a4}
                  - {1'b0, b4}
                  - {{SLICE_W{1'b0}}, bi};

endmodule

// File: rtl/serial_sub_ctrl.sv
// Nibble-serial subtract sequencer driving one sub4_slice.
// Define SERSUB_ZERO_EN to add the registered zero flag.
module serial_sub_ctrl
  import sersub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  serial_sub_ctrl_if.slave bus
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int IW  = idx_w(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic             brw;
  logic [IW-1:0]    idx;
  logic             rdy_r;
  logic             vld_r;
  logic [SLICE_W-1:0] d4;
  logic             bnext;
`ifdef SERSUB_ZERO_EN
  logic             zero_r;
`endif

  sub4_slice u_slice (
    .a4 (a_r[SLICE_W-1:0]),
    .b4 (b_r[SLICE_W-1:0]),
    .bi (brw),
    .d4 (d4),
    .bo (bnext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rdy_r  <= 1'b1;
      vld_r  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      diff_r <= '0;
      brw    <= 1'b0;
      idx    <= '0;
`ifdef SERSUB_ZERO_EN
      zero_r <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            brw   <= bus.bin;
            idx   <= '0;
            rdy_r <= 1'b0;
            state <= RUN;
`ifdef SERSUB_ZERO_EN
            zero_r <= 1'b1;
`endif
          end
        end
        RUN: begin
          a_r    <= a_r >> SLICE_W;
          b_r    <= b_r >> SLICE_W;
          diff_r <= {d4, diff_r[WIDTH-1:SLICE_W]};
          brw    <= bnext;
          idx    <= idx + 1'b1;
`ifdef SERSUB_ZERO_EN
          zero_r <= zero_r & (d4 == '0);
`endif
          if (idx == LAST) begin
            vld_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_r <= 1'b0;
            rdy_r <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          vld_r <= 1'b0;
          rdy_r <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Held low while reset is asserted, even though the state is IDLE.
  assign bus.in_ready  = rdy_r & ~rst;
  assign bus.out_valid = vld_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = brw;
`ifdef SERSUB_ZERO_EN
  assign bus.zero      = zero_r;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=16.
// Also checks the zero flag when SERSUB_ZERO_EN is defined.
module tb_serial_sub_ctrl;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic bi);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.d  = full[W-1:0];
    e.bo = full[W];
    e.z  = (full[W-1:0] == '0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic bi);
    int n;
    bus.a = a;
    bus.b = b;
    bus.bin = bi;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $error("FAIL accept_timeout obs=0 exp=1");
    end
    q.push_back(model(a, b, bi));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      total++;
      bad++;
      $error("FAIL valid_timeout obs=0 exp=1");
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb_empty obs=0 exp=1", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_diff"}, 32'(bus.diff), 32'(e.d));
      chk({tag, "_bout"}, 32'(bus.bout), 32'(e.bo));
`ifdef SERSUB_ZERO_EN
      chk({tag, "_zero"}, 32'(bus.zero), 32'(e.z));
`endif
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic bi);
    int n;
    send(a, b, bi);
    wait_valid(n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    check_out(tag);
    @(negedge clk);
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ir_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int nacc;
    int ndone;
    int last;
    int budget;
    bit pend;
    exp_t e;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERSUB_ZERO_EN
    chk("rst_zero", 32'(bus.zero), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    do_op("t1", 16'h1234, 16'h0234, 1'b0);
    do_op("t2", 16'h0000, 16'h0001, 1'b0);
    do_op("t3", 16'h5A5A, 16'h5A59, 1'b1);
    do_op("t4", 16'h7777, 16'h7777, 1'b1);

    // Backpressure with a pending second operand pair.
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h0222, 1'b0);
    wait_valid(n);
    e = q[0];
    bus.a = 16'h4444;
    bus.b = 16'h1111;
    bus.bin = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", 32'(bus.out_valid), 32'd1);
      chk("bp_diff", 32'(bus.diff), 32'(e.d));
      chk("bp_bout", 32'(bus.bout), 32'(e.bo));
      chk("bp_ir", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check_out("bp1");
    @(negedge clk);
    chk("bp_ir_after", 32'(bus.in_ready), 32'd1);
    chk("bp_ov_after", 32'(bus.out_valid), 32'd0);
    q.push_back(model(16'h4444, 16'h1111, 1'b1));
    @(negedge clk);
    chk("bp_accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("bp2_lat", 32'(n), 32'd4);
    check_out("bp2");
    @(negedge clk);

    // Reset in the middle of an operation.
    send(16'h1234, 16'h1111, 1'b0);
    void'(q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ir", 32'(bus.in_ready), 32'd0);
    chk("mrst_ov", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_ir_after", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_no_ov", 32'(bus.out_valid), 32'd0);
    end
    do_op("t5", 16'h00FF, 16'h000F, 1'b0);

    // Back-to-back random stream.
    nacc = 0;
    ndone = 0;
    last = 0;
    budget = 0;
    pend = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.bin = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
    while (ndone < 20 && budget < 400) begin
      if (pend) begin
        pend = 1'b0;
        if (nacc >= 20) begin
          bus.in_valid = 1'b0;
        end else begin
          bus.a = 16'($urandom);
          bus.b = 16'($urandom);
          bus.bin = 1'($urandom_range(0, 1));
        end
      end
      if (bus.out_valid) begin
        check_out("rnd");
        ndone++;
      end
      if (bus.in_ready && bus.in_valid) begin
        q.push_back(model(bus.a, bus.b, bus.bin));
        if (nacc > 0)
          chk("rnd_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
        nacc++;
        pend = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    chk("rnd_done", 32'(ndone), 32'd20);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Sequencing controller for the nibble-wide borrow-chain subtractor. It accepts a WIDTH-bit operand pair through a valid/ready handshake and drives one 4-bit subtractor slice once per cycle, least-significant nibble first. The borrow is carried between cycles in a flop, and the controller presents the full difference and final borrow through an output valid/ready handshake. It lets wide subtractions reuse a single 4-bit slice instead of a full-width ripple chain.

## Interface
- WIDTH, 16, operand width; multiple of 4, minimum 8; NIB = WIDTH/4 slice passes per operation
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept; high only in IDLE
- a  in  WIDTH  minuend, sampled on accept
- b  in  WIDTH  subtrahend, sampled on accept
- bin  in  1  borrow-in, sampled on accept
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  a − b − bin, modulo 2^WIDTH
- bout  out  1  final borrow; 1 when a < b + bin (unsigned)
- zero  out  1  diff == 0; present only with SERSUB_ZERO_EN

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1, capture a, b and bin into a_r, b_r and brw. Clear idx and go to RUN.
- RUN, once per cycle:
  - Slice computes {bnext, d4} from a_r[3:0], b_r[3:0] and brw.
  - a_r and b_r shift right by 4.
  - diff_r shifts right by 4 with d4 inserted at [WIDTH-1:WIDTH-4].
  - brw takes bnext and idx increments.
  - On the cycle where idx==NIB-1, go to DONE.
- DONE: out_valid=1. diff=diff_r and bout=brw, both held stable until out_ready=1. Then go to IDLE.
- In DONE, out_valid=1 and out_ready=1 returns to IDLE in the same cycle.
- in_valid outside IDLE is ignored. No operand overlap: new operands are accepted only in IDLE.
- Arithmetic:
  - Slice output: d4 = (a4 − b4 − bi) mod 16, bo = (a4 < b4 + bi).
  - Final borrow equals the borrow out of the most significant nibble.
  - bin=1 with a == b gives diff = all-ones and bout=1.
- diff and bout are don't-care while out_valid=0; the bench checks them only with out_valid=1.
- Reset values: state=IDLE, in_ready=0 while rst=1, out_valid=0, diff=0, bout=0, zero=0, idx=0.
- Reset mid-operation: the operation is aborted with no out_valid pulse. The first cycle after rst drops is IDLE with in_ready=1.

## Timing
- Accept edge = T0. RUN occupies edges T1..TNIB, and out_valid rises after edge TNIB.
- Latency: out_valid is first high NIB cycles after the accept cycle; 4 cycles at WIDTH=16.
- Minimum period with out_ready held at 1: NIB+2 cycles per operation (IDLE accept, NIB RUN, one DONE).
- in_ready and out_valid are pure functions of state registers; there is no combinational path from in_valid or out_ready.
- Backpressure in DONE is unbounded; outputs hold for as long as it lasts.

## Configuration
- SERSUB_ZERO_EN defined:
  - zero_r is set to 1 on accept.
  - Each RUN cycle, zero_r <= zero_r & (d4 == 0).
  - zero=zero_r, valid with out_valid and held in DONE.
  - Reset value is 0.
- SERSUB_ZERO_EN undefined: the zero port and zero_r are absent, and all other behaviour is identical.

## Structure
- Package sersub_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - SLICE_W = 4;
  - a function returning the idx counter width, ceil(log2(NIB)) with a minimum of 1.
- Sub-module sub4_slice: combinational 4-bit slice with inputs a4, b4, bi and outputs d4, bo. It is instantiated once.
- All sequencing, shift registers and handshakes live in serial_sub_ctrl.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, zero=0. out_valid first high exactly 4 cycles after the accept cycle.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1 (borrow ripples through all 4 nibbles).
- a=0x5A5A, b=0x5A59, bin=1 → diff=0x0000, bout=0, zero=1 (macro build); zero port absent in the non-macro build.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and a new operand pair applied.
  - out_valid, diff and bout are stable and in_ready=0 throughout.
  - The new pair is accepted only after the result handshake completes.
- rst=1 for one cycle after 2 RUN cycles → out_valid never rises. The next cycle has in_ready=1, and a following a=0x00FF, b=0x000F op yields diff=0x00F0, bout=0.
- Back-to-back random stream with out_ready=1 and in_valid=1 → accepts are spaced exactly 6 cycles apart at WIDTH=16. All results match the scoreboard (a − b − bin) mod 2^16, with bout matching.
